// File: rtl/tri_raster_ctrl.sv
// rtl/tri_raster_ctrl.sv - point-in-triangle raster sequencer with shared edge-function unit
//
// Purpose:
//   Accepts one triangle (three signed vertices) per in_valid/in_ready handshake,
//   computes its bounding box, scans every pixel of the box in raster order and
//   streams each pixel's coordinate plus an inside flag downstream. The three
//   edge functions of a pixel are evaluated one per cycle on a single shared
//   multiply-subtract unit, giving four cycles per pixel with out_ready held high.
//
// Optional build macro:
//   TRI_CLIP_EN - clamp the bounding box to the 0..SCREEN_W-1 / 0..SCREEN_H-1
//                 screen; an empty clipped box emits no pixels.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready    triangle handshake (in_ready high only while idle)
//   v0x..v2y               signed vertex coordinates, sampled on accept only
//   out_valid / out_ready  pixel stream handshake
//   out_x, out_y           signed pixel coordinate
//   out_inside             pixel lies inside or on the triangle
//   out_last               last pixel of the current triangle
//   out_count              saturating inside-pixel count including this pixel
//   busy                   triangle in progress

module tri_raster_ctrl #(
  parameter int CW       = 12,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [CW-1:0] v0x,
  input  logic signed [CW-1:0] v0y,
  input  logic signed [CW-1:0] v1x,
  input  logic signed [CW-1:0] v1y,
  input  logic signed [CW-1:0] v2x,
  input  logic signed [CW-1:0] v2y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [CW-1:0] out_x,
  output logic signed [CW-1:0] out_y,
  output logic                 out_inside,
  output logic                 out_last,
  output logic [23:0]          out_count,
  output logic                 busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BBOX  = 3'd1;
  localparam logic [2:0] S_EVAL0 = 3'd2;
  localparam logic [2:0] S_EVAL1 = 3'd3;
  localparam logic [2:0] S_EVAL2 = 3'd4;
  localparam logic [2:0] S_EMIT  = 3'd5;

  localparam int DW = CW + 1;      // coordinate difference width
  localparam int PW = 2 * CW + 2;  // product width
  localparam int EW = 2 * CW + 3;  // edge-function result width

  localparam logic signed [CW-1:0] C_ONE = CW'(1);

  logic [2:0]           r_state;
  logic signed [CW-1:0] r_v0x, r_v0y, r_v1x, r_v1y, r_v2x, r_v2y;
  logic signed [CW-1:0] r_xmin, r_xmax;
  logic signed [CW-1:0] r_x, r_y;
  logic [2:0]           r_pos;
  logic [2:0]           r_neg;
  logic [23:0]          r_count;

  function automatic logic signed [CW-1:0] smin3(input logic signed [CW-1:0] a,
                                                  input logic signed [CW-1:0] b,
                                                  input logic signed [CW-1:0] c);
    logic signed [CW-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [CW-1:0] smax3(input logic signed [CW-1:0] a,
                                                  input logic signed [CW-1:0] b,
                                                  input logic signed [CW-1:0] c);
    logic signed [CW-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // ---------------------------------------------------------------------------
  // Bounding box of the latched vertices (used during BBOX only)
  // ---------------------------------------------------------------------------
  logic signed [CW-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
  logic signed [CW-1:0] w_xmin_c, w_xmax_c, w_ymin_c, w_ymax_c;
  logic                 w_box_empty;

  assign w_xmin = smin3(r_v0x, r_v1x, r_v2x);
  assign w_xmax = smax3(r_v0x, r_v1x, r_v2x);
  assign w_ymin = smin3(r_v0y, r_v1y, r_v2y);
  assign w_ymax = smax3(r_v0y, r_v1y, r_v2y);

`ifdef TRI_CLIP_EN
  localparam logic signed [CW-1:0] C_XLIM = CW'(SCREEN_W - 1);
  localparam logic signed [CW-1:0] C_YLIM = CW'(SCREEN_H - 1);

  assign w_xmin_c    = (w_xmin < 0) ? '0 : w_xmin;
  assign w_ymin_c    = (w_ymin < 0) ? '0 : w_ymin;
  assign w_xmax_c    = (w_xmax > C_XLIM) ? C_XLIM : w_xmax;
  assign w_ymax_c    = (w_ymax > C_YLIM) ? C_YLIM : w_ymax;
  assign w_box_empty = (w_xmin_c > w_xmax_c) || (w_ymin_c > w_ymax_c);
`else
  assign w_xmin_c    = w_xmin;
  assign w_ymin_c    = w_ymin;
  assign w_xmax_c    = w_xmax;
  assign w_ymax_c    = w_ymax;
  assign w_box_empty = 1'b0;
`endif

  // y extent is only needed for the last-pixel test, so only ymax is kept.
  logic signed [CW-1:0] r_ymax;

  // ---------------------------------------------------------------------------
  // Shared edge-function unit: E(a,b,p) = (bx-ax)*(py-ay) - (by-ay)*(px-ax)
  // The operand pair is selected by the EVAL state; full width, no truncation.
  // ---------------------------------------------------------------------------
  logic signed [CW-1:0] w_ax, w_ay, w_bx, w_by;
  logic signed [DW-1:0] w_dbx, w_dby, w_dpx, w_dpy;
  logic signed [PW-1:0] w_p1, w_p2;
  logic signed [EW-1:0] w_e;
  logic                 w_e_neg, w_e_zero;

  always_comb begin
    w_ax = r_v0x;
    w_ay = r_v0y;
    w_bx = r_v1x;
    w_by = r_v1y;
    case (r_state)
      S_EVAL1: begin
        w_ax = r_v1x; w_ay = r_v1y;
        w_bx = r_v2x; w_by = r_v2y;
      end
      S_EVAL2: begin
        w_ax = r_v2x; w_ay = r_v2y;
        w_bx = r_v0x; w_by = r_v0y;
      end
      default: begin
        w_ax = r_v0x; w_ay = r_v0y;
        w_bx = r_v1x; w_by = r_v1y;
      end
    endcase
  end

  // Sign-extend to CW+1 before subtracting so the difference cannot overflow.
  assign w_dbx = {w_bx[CW-1], w_bx} - {w_ax[CW-1], w_ax};
  assign w_dby = {w_by[CW-1], w_by} - {w_ay[CW-1], w_ay};
  assign w_dpx = {r_x[CW-1], r_x}   - {w_ax[CW-1], w_ax};
  assign w_dpy = {r_y[CW-1], r_y}   - {w_ay[CW-1], w_ay};

  assign w_p1 = PW'(w_dbx) * PW'(w_dpy);
  assign w_p2 = PW'(w_dby) * PW'(w_dpx);
  assign w_e  = EW'(w_p1) - EW'(w_p2);

  assign w_e_neg  = w_e[EW-1];
  assign w_e_zero = (w_e == '0);

  // ---------------------------------------------------------------------------
  // Pixel decision and output stream
  // ---------------------------------------------------------------------------
  logic        w_emit;
  logic        w_inside;
  logic        w_last;
  logic        w_x_end;
  logic [23:0] w_count_next;

  assign w_emit   = (r_state == S_EMIT);
  // Either winding is accepted; a zero edge sets both flags so on-edge pixels
  // (and the line of a collinear triangle) count as inside.
  assign w_inside = (&r_pos) | (&r_neg);
  assign w_x_end  = (r_x == r_xmax);
  assign w_last   = w_x_end && (r_y == r_ymax);

  assign w_count_next = (w_emit && w_inside && (r_count != 24'hFF_FFFF)) ?
                        r_count + 24'd1 : r_count;

  assign in_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign out_valid  = w_emit;
  assign out_x      = r_x;
  assign out_y      = r_y;
  assign out_inside = w_emit && w_inside;
  assign out_last   = w_emit && w_last;
  assign out_count  = w_count_next;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_v0x   <= '0;
      r_v0y   <= '0;
      r_v1x   <= '0;
      r_v1y   <= '0;
      r_v2x   <= '0;
      r_v2y   <= '0;
      r_xmin  <= '0;
      r_xmax  <= '0;
      r_ymax  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_pos   <= '0;
      r_neg   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_v0x   <= v0x;
            r_v0y   <= v0y;
            r_v1x   <= v1x;
            r_v1y   <= v1y;
            r_v2x   <= v2x;
            r_v2y   <= v2y;
            r_count <= '0;
            r_state <= S_BBOX;
          end
        end

        S_BBOX: begin
          r_xmin  <= w_xmin_c;
          r_xmax  <= w_xmax_c;
          r_ymax  <= w_ymax_c;
          r_x     <= w_xmin_c;
          r_y     <= w_ymin_c;
          r_state <= w_box_empty ? S_IDLE : S_EVAL0;
        end

        S_EVAL0: begin
          r_pos[0] <= ~w_e_neg;
          r_neg[0] <= w_e_neg | w_e_zero;
          r_state  <= S_EVAL1;
        end

        S_EVAL1: begin
          r_pos[1] <= ~w_e_neg;
          r_neg[1] <= w_e_neg | w_e_zero;
          r_state  <= S_EVAL2;
        end

        S_EVAL2: begin
          r_pos[2] <= ~w_e_neg;
          r_neg[2] <= w_e_neg | w_e_zero;
          r_state  <= S_EMIT;
        end

        S_EMIT: begin
          if (out_ready) begin
            r_count <= w_count_next;
            // Last-pixel test comes first, so a box reaching the top of the
            // signed range never increments past it.
            if (w_last) begin
              r_state <= S_IDLE;
            end else if (w_x_end) begin
              r_x     <= r_xmin;
              r_y     <= r_y + C_ONE;
              r_state <= S_EVAL0;
            end else begin
              r_x     <= r_x + C_ONE;
              r_state <= S_EVAL0;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_raster_ctrl.sv
// tb/tb_tri_raster_ctrl.sv - directed self-checking bench for tri_raster_ctrl

module tb_tri_raster_ctrl;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [11:0] v0x, v0y, v1x, v1y, v2x, v2y;
  logic               out_valid;
  logic               out_ready;
  logic signed [11:0] out_x, out_y;
  logic               out_inside;
  logic               out_last;
  logic [23:0]        out_count;
  logic               busy;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int g_start = 0;

  int q_x[$];
  int q_y[$];
  int q_in[$];
  int q_last[$];
  int q_cnt[$];
  int q_cyc[$];

  tri_raster_ctrl #(.CW(12), .SCREEN_W(640), .SCREEN_H(480)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .v0x(v0x), .v0y(v0y), .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_inside(out_inside),
    .out_last(out_last), .out_count(out_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint ef(input longint ax, input longint ay, input longint bx,
                                input longint by, input longint px, input longint py);
    return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction

  function automatic int m_inside(input int ax, input int ay, input int bx, input int by,
                                  input int cx, input int cy, input int px, input int py);
    longint e0, e1, e2;
    e0 = ef(ax, ay, bx, by, px, py);
    e1 = ef(bx, by, cx, cy, px, py);
    e2 = ef(cx, cy, ax, ay, px, py);
    return ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0)) ? 1 : 0;
  endfunction

  task automatic send_tri(input int ax, input int ay, input int bx, input int by,
                          input int cx, input int cy);
    for (int i = 0; i < 50 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    v0x = 12'(ax); v0y = 12'(ay);
    v1x = 12'(bx); v1y = 12'(by);
    v2x = 12'(cx); v2y = 12'(cy);
    in_valid = 1'b1;
    g_start = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_tri(input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy, input int max_cyc, output bit timeout);
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    q_x.delete(); q_y.delete(); q_in.delete();
    q_last.delete(); q_cnt.delete(); q_cyc.delete();
    send_tri(ax, ay, bx, by, cx, cy);
    for (int i = 0; i < max_cyc && !done; i++) begin
      if (out_valid) begin
        q_x.push_back(int'(out_x));
        q_y.push_back(int'(out_y));
        q_in.push_back(int'(out_inside));
        q_last.push_back(int'(out_last));
        q_cnt.push_back(int'(out_count));
        q_cyc.push_back(cyc);
        if (out_last) done = 1'b1;
      end
      @(posedge clk); #1;
    end
    timeout = !done;
  endtask

  task automatic test_reset();
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_inside !== 1'b0 ||
        out_last !== 1'b0 || out_x !== 12'sd0 || out_y !== 12'sd0 || out_count !== 24'd0) begin
      tests_failed++;
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b busy=%0b inside=%0b last=%0b x=%0d y=%0d count=%0d, required 1 0 0 0 0 0 0 0",
               in_ready, out_valid, busy, out_inside, out_last, out_x, out_y, out_count);
    end
  endtask

  task automatic test_basic(input string tag, input int bx, input int by, input int cx, input int cy);
    bit to;
    int bad;
    run_tri(0, 0, bx, by, cx, cy, 300, to);
    tests_run++;
    if (to || q_x.size() != 25) begin
      tests_failed++;
      $display("FAIL %s_pixels: got %0d pixels (timeout=%0b), required 25", tag, q_x.size(), to);
      return;
    end
    tests_run++;
    if (q_x[0] != 0 || q_y[0] != 0 || q_in[0] != 1) begin
      tests_failed++;
      $display("FAIL %s_first: (%0d,%0d) inside=%0d, required (0,0) inside=1", tag, q_x[0], q_y[0], q_in[0]);
    end
    tests_run++;
    if (q_x[24] != 4 || q_y[24] != 4 || q_in[24] != 0 || q_last[24] != 1 || q_cnt[24] != 15) begin
      tests_failed++;
      $display("FAIL %s_last: (%0d,%0d) inside=%0d last=%0d count=%0d, required (4,4) 0 1 15",
               tag, q_x[24], q_y[24], q_in[24], q_last[24], q_cnt[24]);
    end
    // Inside region of this right triangle is x+y<=4; raster order row by row.
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      if (q_x[i] != i % 5 || q_y[i] != i / 5 || q_in[i] != ((i % 5 + i / 5 <= 4) ? 1 : 0) ||
          (i < 24 && q_last[i] != 0)) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL %s_pattern: %0d pixels wrong, required 0", tag, bad);
    end
    tests_run++;
    if (q_cyc[0] - g_start != 5) begin
      tests_failed++;
      $display("FAIL %s_latency: %0d cycles, required 5", tag, q_cyc[0] - g_start);
    end
    bad = 0;
    for (int i = 1; i < 25; i++) if (q_cyc[i] - q_cyc[i-1] != 4) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL %s_spacing: %0d gaps not 4 cycles, required 0", tag, bad);
    end
  endtask

  task automatic test_big();
    bit to;
    int xlo, xhi, ylo, yhi, w, n, bad, mcnt, idx;
`ifdef TRI_CLIP_EN
    xlo = 0; xhi = 5; ylo = 0; yhi = 20;
`else
    xlo = -43; xhi = 5; ylo = -4; yhi = 20;
`endif
    w = xhi - xlo + 1;
    n = w * (yhi - ylo + 1);
    run_tri(-17, -4, 5, 15, -43, 20, 8000, to);
    tests_run++;
    if (to || q_x.size() != n) begin
      tests_failed++;
      $display("FAIL big_pixels: got %0d (timeout=%0b), required %0d", q_x.size(), to, n);
      return;
    end
    tests_run++;
    if (q_x[0] != xlo || q_y[0] != ylo || q_x[n-1] != 5 || q_y[n-1] != 20 || q_last[n-1] != 1) begin
      tests_failed++;
      $display("FAIL big_ends: first (%0d,%0d) last (%0d,%0d) last_flag=%0d, required (%0d,%0d) (5,20) 1",
               q_x[0], q_y[0], q_x[n-1], q_y[n-1], q_last[n-1], xlo, ylo);
    end
`ifndef TRI_CLIP_EN
    idx = (12 - ylo) * w + (-14 - xlo);
    tests_run++;
    if (q_x[idx] != -14 || q_y[idx] != 12 || q_in[idx] != 1) begin
      tests_failed++;
      $display("FAIL big_pt_in: (%0d,%0d) inside=%0d, required (-14,12) inside=1", q_x[idx], q_y[idx], q_in[idx]);
    end
    idx = (3 - ylo) * w + (-3 - xlo);
    tests_run++;
    if (q_x[idx] != -3 || q_y[idx] != 3 || q_in[idx] != 0) begin
      tests_failed++;
      $display("FAIL big_pt_out: (%0d,%0d) inside=%0d, required (-3,3) inside=0", q_x[idx], q_y[idx], q_in[idx]);
    end
`endif
    bad = 0;
    mcnt = 0;
    for (int i = 0; i < n; i++) begin
      int ex, ey, ei;
      ex = xlo + i % w;
      ey = ylo + i / w;
      ei = m_inside(-17, -4, 5, 15, -43, 20, ex, ey);
      mcnt += ei;
      if (q_x[i] != ex || q_y[i] != ey || q_in[i] != ei) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL big_pattern: %0d pixels wrong, required 0", bad);
    end
    tests_run++;
    if (q_cnt[n-1] != mcnt) begin
      tests_failed++;
      $display("FAIL big_count: %0d, required %0d", q_cnt[n-1], mcnt);
    end
  endtask

  task automatic test_point();
    bit to;
    run_tri(3, 3, 3, 3, 3, 3, 50, to);
    tests_run++;
    if (to || q_x.size() != 1) begin
      tests_failed++;
      $display("FAIL point_pixels: got %0d (timeout=%0b), required 1", q_x.size(), to);
      return;
    end
    tests_run++;
    if (q_x[0] != 3 || q_y[0] != 3 || q_in[0] != 1 || q_last[0] != 1 || q_cnt[0] != 1) begin
      tests_failed++;
      $display("FAIL point_pixel: (%0d,%0d) inside=%0d last=%0d count=%0d, required (3,3) 1 1 1",
               q_x[0], q_y[0], q_in[0], q_last[0], q_cnt[0]);
    end
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL point_ready: in_ready=%0b busy=%0b, required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_degenerate();
    bit to;
    int bad;
    run_tri(0, 0, 2, 2, 1, 1, 100, to);
    tests_run++;
    if (to || q_x.size() != 9) begin
      tests_failed++;
      $display("FAIL degen_pixels: got %0d (timeout=%0b), required 9", q_x.size(), to);
      return;
    end
    bad = 0;
    for (int i = 0; i < 9; i++) if (q_in[i] != ((i % 3 == i / 3) ? 1 : 0)) bad++;
    tests_run++;
    if (bad != 0 || q_cnt[8] != 3) begin
      tests_failed++;
      $display("FAIL degen_line: %0d wrong, count=%0d, required 0 wrong, count=3", bad, q_cnt[8]);
    end
  endtask

  task automatic test_backpressure();
    int hx, hy, hin, k;
    bit got;
    out_ready = 1'b0;
    send_tri(0, 0, 4, 0, 0, 4);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (out_valid) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL bp_first_valid: out_valid=0, required 1 within 20 cycles");
      return;
    end
    hx = int'(out_x); hy = int'(out_y); hin = int'(out_inside);
    tests_run++;
    if (hx != 0 || hy != 0 || hin != 1) begin
      tests_failed++;
      $display("FAIL bp_first_pixel: (%0d,%0d) inside=%0d, required (0,0) 1", hx, hy, hin);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || int'(out_x) != hx || int'(out_y) != hy ||
          int'(out_inside) != hin || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: valid=%0b (%0d,%0d) inside=%0b in_ready=%0b, required 1 (0,0) 1 0",
                 i, out_valid, out_x, out_y, out_inside, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (out_valid) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    tests_run++;
    if (!got || out_x !== 12'sd1 || out_y !== 12'sd0) begin
      tests_failed++;
      $display("FAIL bp_resume: valid=%0b (%0d,%0d), required 1 (1,0)", got, out_x, out_y);
    end
    k = 0;
    got = 1'b0;
    while (k < 200 && !got) begin
      if (out_valid && out_last) got = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL bp_drain: out_last not seen, required within 200 cycles");
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit to;
    out_ready = 1'b1;
    send_tri(0, 0, 4, 0, 0, 4);
    n = 0;
    for (int i = 0; i < 100 && n < 5; i++) begin
      if (out_valid) n++;
      if (n < 5) begin @(posedge clk); #1; end
    end
    tests_run++;
    if (n != 5) begin
      tests_failed++;
      $display("FAIL rst_mid_reach: %0d pixels seen, required 5", n);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_async: valid=%0b busy=%0b in_ready=%0b last=%0b, required 0 0 1 0",
               out_valid, busy, in_ready, out_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_tri(2, 2, 3, 2, 2, 3, 100, to);
    tests_run++;
    if (to || q_x.size() != 4 || q_x[0] != 2 || q_y[0] != 2 || q_cnt[0] != 1 || q_cnt[3] != 3) begin
      tests_failed++;
      $display("FAIL rst_mid_restart: n=%0d first=(%0d,%0d) cnt0=%0d, required n=4 (2,2) cnt0=1 final=3",
               q_x.size(), (q_x.size() > 0) ? q_x[0] : -999, (q_y.size() > 0) ? q_y[0] : -999,
               (q_cnt.size() > 0) ? q_cnt[0] : -1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    v0x = '0; v0y = '0; v1x = '0; v1y = '0; v2x = '0; v2y = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic("tri1", 4, 0, 0, 4);
    test_basic("tri1_rev", 0, 4, 4, 0);
    test_big();
    test_point();
    test_degenerate();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
